instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// Multicycle fetch stage: owns the PC, reads one 16-bit instruction word per fetch over a req/ready memory handshake,
// holds it in the instruction register (IR) and splits it into fields. imm8 drives the 8-to-16 zero extender;
// opcode/rd/rs1/rs2 go to control unit and register file. The control unit starts each fetch and may redirect the PC.
// PARAMETERS
// DATA_W    16       instruction / memory data width
// ADDR_W    16       PC / memory address width
// PC_RESET  16'h0000 PC value after reset
// PC_STEP   2        PC increment per completed fetch (byte-addressed 16-bit words)
// TIMEOUT   15       max FETCH cycles waiting for mem_ready before abort (>=1)
// PORTS
// clk          in   1       system clock, rising edge
// reset        in   1       asynchronous, active-high
// fetch_start  in   1       control unit: begin a fetch (sampled in IDLE only)
// pc_load      in   1       control unit: load pc_target into PC (branch/jump)
// pc_target    in   ADDR_W  new PC value
// mem_req      out  1       read request, held high through FETCH
// mem_addr     out  ADDR_W  read address, = pc while mem_req high
// mem_rdata    in   DATA_W  instruction word, valid when mem_ready=1
// mem_ready    in   1       memory has data this cycle
// pc           out  ADDR_W  current PC
// ir           out  DATA_W  instruction register
// opcode       out  4       ir[15:12]
// rd           out  3       ir[11:9]
// rs1          out  3       ir[8:6]
// rs2          out  3       ir[5:3]
// imm8         out  8       ir[7:0], to zero extender
// ir_valid     out  1       1-cycle pulse: ir updated by a completed fetch
// busy         out  1       1 in FETCH or DONE
// fetch_err    out  1       sticky timeout flag, cleared by the next accepted fetch_start
// BEHAVIOUR
// - Reset (async): state=IDLE, pc=PC_RESET, ir=0, mem_req=0, ir_valid=0, fetch_err=0, wait counter=0. All outputs registered.
// - Fields are pure slices of ir; they change only when ir changes. Reset mid-fetch drops mem_req immediately, nothing latched.
// - FSM states IDLE, FETCH, DONE:
//   IDLE : fetch_start=1 -> FETCH, mem_req<=1, counter<=0, fetch_err<=0. Otherwise stay.
//   FETCH: mem_ready=1 -> ir<=mem_rdata, pc<=pc+PC_STEP (mod 2^ADDR_W), mem_req<=0, ir_valid<=1, -> DONE.
//          mem_ready=0 and counter==TIMEOUT-1 -> mem_req<=0, fetch_err<=1, ir/pc unchanged, -> IDLE.
//          else counter<=counter+1.
//   DONE : ir_valid<=0, -> IDLE (unconditional; fetch_start here is ignored).
// - Latency: fetch_start at edge N -> mem_req high from N+1; mem_ready at edge N+1 gives ir_valid high in N+1..N+2 (min 2 cycles).
// - mem_ready outside FETCH is ignored. fetch_start in FETCH/DONE is ignored (no queueing).
// - pc_load: honoured in IDLE and DONE; ignored in FETCH (address stable for whole request).
//   In DONE, pc_load overrides the increment written that edge's predecessor, i.e. pc<=pc_target.
//   pc_load and fetch_start same IDLE cycle: pc<=pc_target, FETCH begins; mem_addr = pc_target.
// - PC wraps 16'hFFFE + 2 -> 16'h0000 silently. Odd pc_target values are accepted unchanged.
// - Counter width = $clog2(TIMEOUT+1); counter never exceeds TIMEOUT-1.
// STRUCTURE
// - Shared package isa_pkg: opcode localparams, field bit positions (OPC_HI/LO, RD_HI/LO, RS1_*, RS2_*, IMM8_*),
//   state encoding localparams (S_IDLE, S_FETCH, S_DONE), INSTR_W=16.
// - Single module, no sub-modules: one sequential FSM/datapath always block with async reset, field assigns continuous.
// TESTING
// 1 reset with PC_RESET=0; fetch_start, mem_ready=1 next cycle, mem_rdata=16'h5A3C -> ir=5A3C, opcode=5, imm8=3C, pc=2, ir_valid 1 cycle.
// 2 mem_ready delayed 3 cycles -> mem_req high 4 cycles, mem_addr=0002 throughout, ir_valid once, pc=4.
// 3 mem_ready never asserted, TIMEOUT=15 -> mem_req drops after 15 FETCH cycles, fetch_err=1, pc/ir unchanged; next fetch_start clears it.
// 4 pc_load=1, pc_target=16'h0100 with fetch_start same cycle -> mem_addr=0100; pc_load pulsed during FETCH -> pc unchanged.
// 5 pc_target=16'hFFFE, fetch completes -> pc=0000; reset asserted mid-FETCH -> mem_req=0 and pc=0 immediately, no ir_valid.

Source files
------------

// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isa_pkg
//  Description : Shared ISA definitions for the fetch stage and its consumers:
//                instruction width, opcode values, instruction field bit
//                positions and the fetch FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package isa_pkg;

    localparam int INSTR_W = 16;

    // Opcode values carried in ir[15:12]
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_LDI  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;

    // Instruction field bit positions
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 9;
    localparam int RS1_HI  = 8;
    localparam int RS1_LO  = 6;
    localparam int RS2_HI  = 5;
    localparam int RS2_LO  = 3;
    localparam int IMM8_HI = 7;
    localparam int IMM8_LO = 0;

    // Fetch FSM state encoding
    localparam int         STATE_W = 2;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Multicycle fetch stage. Owns the PC, reads one instruction
//                word per fetch over a req/ready handshake, holds it in the
//                instruction register and splits it into decode fields.
//  Ports       : clk, reset (async, active-high)
//                fetch_start, pc_load, pc_target       - from control unit
//                mem_req, mem_addr / mem_rdata, mem_ready - memory port
//                pc, ir, opcode, rd, rs1, rs2, imm8     - fetch results
//                ir_valid (1-cycle pulse), busy, fetch_err (sticky timeout)
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import isa_pkg::*;
#(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] PC_RESET = '0,
    parameter int              PC_STEP  = 2,
    parameter int              TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        opcode,
    output logic [2:0]        rd,
    output logic [2:0]        rs1,
    output logic [2:0]        rs2,
    output logic [7:0]        imm8,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] C_PC_STEP  = ADDR_W'(PC_STEP);

    logic [STATE_W-1:0] r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_pc;
    logic [DATA_W-1:0]  r_ir;
    logic               r_mem_req;
    logic               r_ir_valid;
    logic               r_busy;
    logic               r_fetch_err;

    // Single FSM/datapath process. busy is kept as its own register so every
    // output comes straight from a flop rather than from state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pc        <= PC_RESET;
            r_ir        <= '0;
            r_mem_req   <= 1'b0;
            r_ir_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A same-cycle pc_load redirects the fetch that starts now,
                    // since mem_addr follows the PC register.
                    if (pc_load) begin
                        r_pc <= pc_target;
                    end
                    if (fetch_start) begin
                        r_state     <= S_FETCH;
                        r_mem_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_fetch_err <= 1'b0;
                    end
                end
                S_FETCH: begin
                    // pc_load is ignored here: the address must stay stable
                    // for the whole request.
                    if (mem_ready) begin
                        r_ir       <= mem_rdata;
                        r_pc       <= r_pc + C_PC_STEP;
                        r_mem_req  <= 1'b0;
                        r_ir_valid <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_mem_req   <= 1'b0;
                        r_busy      <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // A branch decided on the fresh instruction replaces the
                    // sequential increment written on the previous edge.
                    if (pc_load) begin
                        r_pc <= pc_target;
                    end
                    r_ir_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_mem_req  <= 1'b0;
                    r_ir_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_pc;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign ir_valid  = r_ir_valid;
    assign busy      = r_busy;
    assign fetch_err = r_fetch_err;

    // Decode fields are pure slices of the instruction register
    assign opcode = r_ir[OPC_HI:OPC_LO];
    assign rd     = r_ir[RD_HI:RD_LO];
    assign rs1    = r_ir[RS1_HI:RS1_LO];
    assign rs2    = r_ir[RS2_HI:RS2_LO];
    assign imm8   = r_ir[IMM8_HI:IMM8_LO];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. Directed table of
//                fetch transactions, hand-written reset sequences, then
//                randomized transactions checked against a transaction-level
//                model of PC / IR / error state.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        reset;
    logic        fetch_start;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [7:0]  imm8;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;

    instr_fetch_unit #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .PC_RESET (16'h0000),
        .PC_STEP  (2),
        .TIMEOUT  (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .pc          (pc),
        .ir          (ir),
        .opcode      (opcode),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm8        (imm8),
        .ir_valid    (ir_valid),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Transaction-level model state
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic        m_err;

    typedef struct {
        logic        ld;
        logic [15:0] tgt;
        int          dly;      // wait cycles before mem_ready; >= TIMEOUT means never
        logic [15:0] rdata;
        logic [15:0] e_pc;
        logic [15:0] e_ir;
        logic        e_err;
        int          e_req;    // cycles mem_req is seen high
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One complete fetch transaction. Counts mem_req cycles, ir_valid pulses
    // and cycles where the address or busy was wrong during the request.
    task automatic do_fetch(input logic ld, input logic [15:0] tgt, input int dly,
                            input logic [15:0] rdv, input logic noise,
                            output int req_n, output int vld_n, output int bad_n);
        logic [15:0] addr_exp;
        int guard;
        addr_exp = ld ? tgt : m_pc;
        req_n = 0; vld_n = 0; bad_n = 0; guard = 0;
        @(negedge clk);
        fetch_start = 1'b1; pc_load = ld; pc_target = tgt;
        @(negedge clk);
        fetch_start = 1'b0; pc_load = 1'b0;
        while (mem_req && guard < 40) begin
            req_n++;
            if (mem_addr !== addr_exp || busy !== 1'b1) bad_n++;
            mem_ready = (req_n - 1 == dly);
            mem_rdata = mem_ready ? rdv : 16'($urandom);
            if (noise) begin
                pc_load     = 1'($urandom_range(0, 1));
                pc_target   = 16'($urandom);
                fetch_start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            guard++;
            if (ir_valid) vld_n++;
        end
        if (guard >= 40) chk("fetch_bound", 32'd1, 32'd0);
        mem_ready = 1'b0; pc_load = 1'b0; fetch_start = 1'b0;
        @(negedge clk);
        if (ir_valid) vld_n++;
    endtask

    task automatic check_result(input string tag, input int req_n, input int vld_n,
                                input int bad_n, input int e_req, input logic e_ok);
        chk({tag, "_pc"},   32'(pc),        32'(m_pc));
        chk({tag, "_ir"},   32'(ir),        32'(m_ir));
        chk({tag, "_err"},  32'(fetch_err), 32'(m_err));
        chk({tag, "_req"},  32'(req_n),     32'(e_req));
        chk({tag, "_vld"},  32'(vld_n),     e_ok ? 32'd1 : 32'd0);
        chk({tag, "_addr"}, 32'(bad_n),     32'd0);
        chk({tag, "_busy"}, 32'(busy),      32'd0);
    endtask

    initial begin
        int req_n, vld_n, bad_n;
        logic [15:0] t;

        tbl[0] = '{1'b0, 16'h0000, 0,  16'h5A3C, 16'h0002, 16'h5A3C, 1'b0, 1};
        tbl[1] = '{1'b0, 16'h0000, 3,  16'h1234, 16'h0004, 16'h1234, 1'b0, 4};
        tbl[2] = '{1'b0, 16'h0000, 99, 16'hDEAD, 16'h0004, 16'h1234, 1'b1, TIMEOUT};
        tbl[3] = '{1'b1, 16'h0100, 1,  16'hABCD, 16'h0102, 16'hABCD, 1'b0, 2};
        tbl[4] = '{1'b1, 16'hFFFE, 0,  16'h0F0F, 16'h0000, 16'h0F0F, 1'b0, 1};

        reset = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; pc_target = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        #3;
        chk("rst_pc",    32'(pc),        32'h0);
        chk("rst_ir",    32'(ir),        32'h0);
        chk("rst_req",   32'(mem_req),   32'h0);
        chk("rst_vld",   32'(ir_valid),  32'h0);
        chk("rst_err",   32'(fetch_err), 32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        @(negedge clk);
        reset = 1'b0;
        m_pc = 16'h0000; m_ir = 16'h0000; m_err = 1'b0;

        // Directed table; row 3 also pulses pc_load during FETCH
        for (int i = 0; i < 5; i++) begin
            do_fetch(tbl[i].ld, tbl[i].tgt, tbl[i].dly, tbl[i].rdata, (i == 3),
                     req_n, vld_n, bad_n);
            m_pc = tbl[i].e_pc; m_ir = tbl[i].e_ir; m_err = tbl[i].e_err;
            check_result($sformatf("tbl%0d", i), req_n, vld_n, bad_n,
                         tbl[i].e_req, !tbl[i].e_err);
            if (i == 0) begin
                chk("t0_opcode", 32'(opcode), 32'h5);
                chk("t0_rd",     32'(rd),     32'h5);
                chk("t0_rs1",    32'(rs1),    32'h0);
                chk("t0_rs2",    32'(rs2),    32'h7);
                chk("t0_imm8",   32'(imm8),   32'h3C);
            end
        end

        // Move the PC off zero, then reset in the middle of a fetch
        @(negedge clk); pc_load = 1'b1; pc_target = 16'h1234;
        @(negedge clk); pc_load = 1'b0;
        chk("idle_load", 32'(pc), 32'h1234);
        fetch_start = 1'b1;
        @(negedge clk); fetch_start = 1'b0;
        @(negedge clk);
        chk("mid_req", 32'(mem_req), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("arst_req",  32'(mem_req), 32'h0);
        chk("arst_pc",   32'(pc),      32'h0);
        chk("arst_busy", 32'(busy),    32'h0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("arst_vld", 32'(ir_valid), 32'h0);
        chk("arst_ir",  32'(ir),       32'h0);
        m_pc = 16'h0000; m_ir = 16'h0000; m_err = 1'b0;

        // Randomized transactions against the model
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                // Idle redirect with stray mem_ready that must be ignored
                t = 16'($urandom);
                @(negedge clk);
                pc_load = 1'b1; pc_target = t; mem_ready = 1'b1; mem_rdata = 16'($urandom);
                @(negedge clk);
                pc_load = 1'b0; mem_ready = 1'b0;
                m_pc = t;
                chk("rnd_idle_pc",  32'(pc),       32'(m_pc));
                chk("rnd_idle_ir",  32'(ir),       32'(m_ir));
                chk("rnd_idle_vld", 32'(ir_valid), 32'h0);
            end else begin
                logic        ld;
                logic [15:0] tg;
                logic [15:0] rv;
                int          dly;
                ld  = ($urandom_range(0, 3) == 0);
                tg  = 16'($urandom);
                rv  = 16'($urandom);
                dly = $urandom_range(0, 20);
                do_fetch(ld, tg, dly, rv, 1'b1, req_n, vld_n, bad_n);
                if (ld) m_pc = tg;
                if (dly < TIMEOUT) begin
                    m_ir  = rv;
                    m_pc  = m_pc + 16'd2;
                    m_err = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
                check_result("rnd", req_n, vld_n, bad_n,
                             (dly < TIMEOUT) ? dly + 1 : TIMEOUT, dly < TIMEOUT);
                chk("rnd_opcode", 32'(opcode), 32'(m_ir[15:12]));
                chk("rnd_imm8",   32'(imm8),   32'(m_ir[7:0]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
